// File: rtl/mm_arb_pkg.sv
// Shared types and job-shape constants for the matrix-multiplier job arbiter.
// The state encoding is fixed so the debug output keeps a stable meaning.
package mm_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      LOAD  = ST_LOAD,
      DRAIN = ST_DRAIN
   } state_t;

   localparam int W_BEATS   = 64;
   localparam int X_BEATS   = 8;
   localparam int RES_BEATS = 8;

   localparam int BEAT_CNT_W = 7;
   localparam int RES_CNT_W  = 3;

   // Index of the final input beat of a job, chosen by its head beat.
   function automatic logic [BEAT_CNT_W-1:0] last_beat(input logic new_matrix);
      return new_matrix ? BEAT_CNT_W'(W_BEATS + X_BEATS - 1) : BEAT_CNT_W'(X_BEATS - 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set bit of elig at or after ptr,
// wrapping at N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  elig,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [2*N-1:0] rot;

   // Doubling the vector lets a plain right shift act as a rotate.
   assign rot = {elig, elig} >> ptr;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            if (int'(ptr) + k >= N) idx = IW'(int'(ptr) + k - N);
            else                    idx = IW'(int'(ptr) + k);
         end
      end
   end

endmodule

// File: rtl/mm_job_arbiter.sv
// Round-robin arbiter granting a shared matrix-vector multiplier to one
// requester per job, returning that job's results and tracking weight ownership.
module mm_job_arbiter
   import mm_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int RES_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ-1:0]          req_new_matrix,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [RES_W-1:0]          rsp_data,
   input  logic [N_REQ-1:0]          rsp_ready,
   output logic                      mm_input_valid,
   output logic                      mm_new_matrix,
   output logic [DATA_W-1:0]         mm_data,
   input  logic                      mm_input_ready,
   input  logic                      mm_output_valid,
   input  logic [RES_W-1:0]          mm_output_data,
   output logic                      mm_output_ready,
   output logic                      busy,
   output logic [$clog2(N_REQ)-1:0]  gnt_idx,
   output logic                      w_owner_valid,
   output logic [$clog2(N_REQ)-1:0]  w_owner,
   output logic [1:0]                state_dbg
);

   localparam int IW = $clog2(N_REQ);

   // Handshakes: a beat or result transfers in a cycle where valid and ready
   // are both high at the rising edge; valid never waits on ready.

   state_t                  state;
   logic [IW-1:0]           rr_ptr;
   logic                    job_nm;
   logic [BEAT_CNT_W-1:0]   beat_cnt;
   logic [RES_CNT_W-1:0]    res_cnt;
   logic [N_REQ-1:0]        elig;
   logic                    pick_found;
   logic [IW-1:0]           pick_idx;
   logic [IW-1:0]           next_ptr;
   logic [DATA_W-1:0]       gnt_data;
   logic                    in_hs;
   logic                    out_hs;

   // An x-only job may only run against weights its requester already loaded.
   always_comb begin
      elig = '0;
      for (int i = 0; i < N_REQ; i++) begin
         elig[i] = req_valid[i] && (req_new_matrix[i] || (w_owner_valid && w_owner == IW'(i)));
      end
   end

   rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .elig  (elig),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == IW'(i)) gnt_data = req_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      req_ready       = '0;
      rsp_valid       = '0;
      mm_input_valid  = 1'b0;
      mm_new_matrix   = 1'b0;
      mm_output_ready = 1'b0;
      case (state)
         LOAD: begin
            mm_input_valid     = req_valid[gnt_idx];
            req_ready[gnt_idx] = mm_input_ready;
            mm_new_matrix      = job_nm && (beat_cnt == '0);
         end
         DRAIN: begin
            rsp_valid[gnt_idx] = mm_output_valid;
            mm_output_ready    = rsp_ready[gnt_idx];
         end
         default: ;
      endcase
   end

   assign mm_data   = gnt_data;
   assign rsp_data  = mm_output_data;
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign in_hs     = mm_input_valid && mm_input_ready;
   assign out_hs    = mm_output_valid && mm_output_ready;
   assign next_ptr  = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         gnt_idx       <= '0;
         w_owner       <= '0;
         w_owner_valid <= 1'b0;
         job_nm        <= 1'b0;
         beat_cnt      <= '0;
         res_cnt       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  gnt_idx  <= pick_idx;
                  job_nm   <= req_new_matrix[pick_idx];
                  beat_cnt <= '0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               if (in_hs) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == last_beat(job_nm)) begin
                     res_cnt <= '0;
                     state   <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (out_hs) begin
                  res_cnt <= res_cnt + 1'b1;
                  if (res_cnt == RES_CNT_W'(RES_BEATS - 1)) begin
                     state  <= IDLE;
                     rr_ptr <= next_ptr;
                     // A weight load, even by the current owner, hands ownership to this requester.
                     if (job_nm) begin
                        w_owner       <= gnt_idx;
                        w_owner_valid <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Directed-sequence bench for mm_job_arbiter with randomized handshakes, acting
// as requesters and multiplier, checked against a job-level ownership/rr model.
module tb_mm_job_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int RW = 32;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_new_matrix;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      rsp_valid;
   logic [RW-1:0]     rsp_data;
   logic [N-1:0]      rsp_ready;
   logic              mm_input_valid;
   logic              mm_new_matrix;
   logic [DW-1:0]     mm_data;
   logic              mm_input_ready;
   logic              mm_output_valid;
   logic [RW-1:0]     mm_output_data;
   logic              mm_output_ready;
   logic              busy;
   logic [1:0]        gnt_idx;
   logic              w_owner_valid;
   logic [1:0]        w_owner;
   logic [1:0]        state_dbg;

   mm_job_arbiter #(
      .N_REQ  (N),
      .DATA_W (DW),
      .RES_W  (RW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_new_matrix  (req_new_matrix),
      .req_data        (req_data),
      .req_ready       (req_ready),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .rsp_ready       (rsp_ready),
      .mm_input_valid  (mm_input_valid),
      .mm_new_matrix   (mm_new_matrix),
      .mm_data         (mm_data),
      .mm_input_ready  (mm_input_ready),
      .mm_output_valid (mm_output_valid),
      .mm_output_data  (mm_output_data),
      .mm_output_ready (mm_output_ready),
      .busy            (busy),
      .gnt_idx         (gnt_idx),
      .w_owner_valid   (w_owner_valid),
      .w_owner         (w_owner),
      .state_dbg       (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Job-level model: -1 idle, 0 x-only job waiting, 1 new-matrix job waiting.
   int pend [N];
   int m_rr, m_own, m_last_g;
   bit m_ov;

   logic [DW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic report();
      $display("Result: errors=%0d of %0d checks", errors, checks);
   endtask

   function automatic int model_pick();
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (pend[i] == 1 || (pend[i] == 0 && m_ov && m_own == i)) return i;
      end
      return -1;
   endfunction

   task automatic drive_pending();
      for (int i = 0; i < N; i++) begin
         req_valid[i]            = (pend[i] >= 0);
         req_new_matrix[i]       = (pend[i] == 1);
         req_data[i*DW +: DW]    = DW'($urandom_range(255));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},      busy, 0);
      check({tag, "_req_ready"}, req_ready, 0);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_in_valid"},  mm_input_valid, 0);
      check({tag, "_new_mat"},   mm_new_matrix, 0);
      check({tag, "_out_ready"}, mm_output_ready, 0);
      check({tag, "_own_valid"}, w_owner_valid, m_ov);
      check({tag, "_owner"},     w_owner, m_own);
      check({tag, "_gnt"},       gnt_idx, m_last_g);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int c = 0; c < n; c++) begin
         drive_pending();
         mm_input_ready  = 1'b1;
         mm_output_valid = 1'b1;
         mm_output_data  = $urandom;
         rsp_ready       = '1;
         @(negedge clk);
         check_idle_outputs(tag);
         check({tag, "_rsp_data"}, rsp_data, mm_output_data);
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) pend[i] = -1;
      m_rr = 0; m_own = 0; m_ov = 1'b0; m_last_g = 0;
      exp_q.delete();
      drive_pending();
      mm_input_ready  = 1'b1;
      mm_output_valid = 1'b1;
      mm_output_data  = $urandom;
      rsp_ready       = '1;
      @(negedge clk);
      check_idle_outputs("reset");
      check("reset_state", state_dbg, 0);
      @(posedge clk); #1;
   endtask

   // driver: one whole job, bench plays requesters and multiplier
   task automatic run_job(input int v_pct, input int r_pct, input int hold,
                          input int abort_at, input bit repend, input int want_g);
      int g, len, sent, nres, cyc, hcnt;
      bit nm, v, r, presenting;
      logic [DW-1:0] b;
      logic [DW-1:0] send_q[$];
      logic [RW-1:0] res_val;
      g = model_pick();
      if (g < 0) begin
         $display("note: no eligible requester, job skipped");
         return;
      end
      nm  = (pend[g] == 1);
      len = nm ? 72 : 8;
      exp_q.delete();
      for (int k = 0; k < len; k++) begin
         b = DW'($urandom_range(255));
         send_q.push_back(b);
         exp_q.push_back(b);
      end

      // arbitration bubble
      drive_pending();
      mm_input_ready  = 1'b1;
      mm_output_valid = 1'b0;
      rsp_ready       = '1;
      @(negedge clk);
      check_idle_outputs("arb");
      @(posedge clk); #1;

      sent = 0; cyc = 0;
      while (sent < len && cyc < 3000) begin
         drive_pending();
         v = ($urandom_range(99) < v_pct);
         r = ($urandom_range(99) < r_pct);
         req_valid[g]          = v;
         req_data[g*DW +: DW]  = send_q[sent];
         mm_input_ready        = r;
         mm_output_valid       = 1'($urandom_range(1));
         mm_output_data        = $urandom;
         rsp_ready             = N'($urandom);
         @(negedge clk);
         if (cyc == 0 && want_g >= 0) check("gnt_order", gnt_idx, want_g);
         check("load_busy",      busy, 1);
         check("load_gnt",       gnt_idx, g);
         check("load_in_valid",  mm_input_valid, v);
         check("load_req_ready", req_ready, r ? (1 << g) : 0);
         check("load_new_mat",   mm_new_matrix, nm && sent == 0);
         check("load_rsp_valid", rsp_valid, 0);
         check("load_out_ready", mm_output_ready, 0);
         if (v && r) begin
            check("load_data", mm_data, exp_q.pop_front());
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
         if (abort_at >= 0 && sent == abort_at) return;
      end
      if (sent < len) begin
         check("load_timeout", sent, len);
         report();
         $fatal(1, "load phase stalled");
      end

      nres = 0; cyc = 0; hcnt = 0; presenting = 1'b0; res_val = '0;
      while (nres < 8 && cyc < 3000) begin
         drive_pending();
         req_valid[g]      = 1'b1;
         req_new_matrix[g] = nm;
         mm_input_ready    = 1'b1;
         if (!presenting) begin
            presenting = (hcnt < hold) || ($urandom_range(99) < 70);
            if (presenting) res_val = $urandom;
         end
         mm_output_valid = presenting;
         mm_output_data  = presenting ? res_val : $urandom;
         rsp_ready       = N'($urandom);
         if (hcnt < hold) begin
            rsp_ready[g] = 1'b0;
            hcnt++;
         end else begin
            rsp_ready[g] = ($urandom_range(99) < r_pct);
         end
         @(negedge clk);
         check("drain_busy",      busy, 1);
         check("drain_gnt",       gnt_idx, g);
         check("drain_req_ready", req_ready, 0);
         check("drain_in_valid",  mm_input_valid, 0);
         check("drain_rsp_valid", rsp_valid, presenting ? (1 << g) : 0);
         check("drain_out_ready", mm_output_ready, rsp_ready[g]);
         check("drain_rsp_data",  rsp_data, presenting ? res_val : mm_output_data);
         if (presenting && rsp_ready[g]) begin
            nres++;
            presenting = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (nres < 8) begin
         check("drain_timeout", nres, 8);
         report();
         $fatal(1, "drain phase stalled");
      end
      mm_output_valid = 1'b0;

      if (nm) begin
         m_own = g;
         m_ov  = 1'b1;
      end
      m_rr     = (g + 1) % N;
      m_last_g = g;
      if (!repend) pend[g] = -1;
   endtask

   initial begin
      rst             = 1'b1;
      req_valid       = '0;
      req_new_matrix  = '0;
      req_data        = '0;
      rsp_ready       = '0;
      mm_input_ready  = 1'b0;
      mm_output_valid = 1'b0;
      mm_output_data  = '0;
      for (int i = 0; i < N; i++) pend[i] = -1;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // x-only job with no owner is never granted
      pend[0] = 0;
      idle_cycles(20, "xonly_no_owner");
      pend[0] = -1;

      // full-throughput new-matrix job from requester 1
      pend[1] = 1;
      run_job(100, 100, 0, -1, 1'b0, 1);
      idle_cycles(2, "owner1");

      // three requesters hold new-matrix jobs from rr_ptr 0
      do_reset();
      pend[0] = 1; pend[2] = 1; pend[3] = 1;
      run_job(70, 60, 0, -1, 1'b1, 0);
      run_job(70, 60, 0, -1, 1'b1, 2);
      run_job(70, 60, 0, -1, 1'b1, 3);
      run_job(70, 60, 0, -1, 1'b0, 0);
      pend[2] = -1; pend[3] = -1;

      // owner x-only job wins over a non-owner x-only job; results held 5 cycles
      pend[0] = 0; pend[1] = 0;
      run_job(50, 50, 5, -1, 1'b0, 0);
      idle_cycles(10, "xonly_non_owner");
      pend[1] = -1;

      // owner reloads its own weights, then ownership moves to 3
      pend[0] = 1;
      run_job(60, 60, 2, -1, 1'b0, 0);
      pend[3] = 1;
      run_job(80, 80, 0, -1, 1'b0, 3);
      idle_cycles(2, "owner3");
      pend[3] = 0;
      run_job(100, 100, 0, -1, 1'b0, 3);

      // reset at load beat 30, then a fresh job from requester 2
      pend[1] = 1;
      run_job(100, 100, 0, 30, 1'b0, 1);
      do_reset();
      pend[2] = 1;
      run_job(100, 100, 0, -1, 1'b0, 2);
      idle_cycles(3, "final");

      report();
      $finish;
   end

endmodule
